// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data, RAM and status signals around the memory port arbiter.
// The arbiter uses the slave view; the CPU core and RAM together form the master view.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_kill;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_wmask;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        stall_if;
    logic        stall_mem;
    logic        m_ce;
    logic        m_we;
    logic [3:0]  m_wmask;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        busy;

    modport slave (
        input  i_req, i_addr, i_kill, d_req, d_we, d_wmask, d_addr, d_wdata, m_rdata,
        output i_rdata, i_done, d_rdata, d_done, stall_if, stall_mem,
               m_ce, m_we, m_wmask, m_addr, m_wdata, busy
    );

    modport master (
        output i_req, i_addr, i_kill, d_req, d_we, d_wmask, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_done, d_rdata, d_done, stall_if, stall_mem,
               m_ce, m_we, m_wmask, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the MEM stage.
// Data has priority; a streak counter forces a fetch grant after STARVE_MAX data wins.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               resetn,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state, stateNext;
    logic [3:0]  latCnt;
    logic [3:0]  streak;
    logic        ownData;
    logic        killFlag;
    logic        iElig, dElig;
    logic        grantFetch, grantData;
    logic [31:0] addrSel;

    assign bus.stall_if  = bus.i_req & ~bus.i_done;
    assign bus.stall_mem = bus.d_req & ~bus.d_done;
    assign bus.busy      = (state != IDLE);

    // A requester whose done is pulsing this cycle still shows its old req; skip it.
    always_comb begin
        iElig      = bus.i_req & ~bus.i_kill & ~bus.i_done;
        dElig      = bus.d_req & ~bus.d_done;
        grantFetch = 1'b0;
        grantData  = 1'b0;
        stateNext  = state;
        case (state)
            IDLE: begin
                if (iElig && (!dElig || streak == STREAK_MAX)) begin
                    grantFetch = 1'b1;
                    stateNext  = ISSUE;
                end else if (dElig) begin
                    grantData = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE:   stateNext = bus.m_we ? IDLE : WAIT;
            WAIT:    if (latCnt == 4'd1) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        addrSel = grantFetch ? bus.i_addr : bus.d_addr;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            latCnt      <= 4'd0;
            streak      <= 4'd0;
            ownData     <= 1'b0;
            killFlag    <= 1'b0;
            bus.m_ce    <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_wmask <= 4'b0;
            bus.m_addr  <= 32'b0;
            bus.m_wdata <= 32'b0;
            bus.i_rdata <= 32'b0;
            bus.d_rdata <= 32'b0;
            bus.i_done  <= 1'b0;
            bus.d_done  <= 1'b0;
        end else begin
            state      <= stateNext;
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantFetch || grantData) begin
                        bus.m_ce    <= 1'b1;
                        bus.m_we    <= grantData & bus.d_we;
                        bus.m_wmask <= (grantData & bus.d_we) ? bus.d_wmask : 4'b0;
                        bus.m_addr  <= addrSel & ~32'h3;
                        bus.m_wdata <= grantData ? bus.d_wdata : 32'b0;
                        ownData     <= grantData;
                        killFlag    <= 1'b0;
                        // Only data wins taken over a waiting fetch count toward starvation.
                        if (grantData && bus.i_req) begin
                            if (streak != STREAK_MAX) streak <= streak + 4'd1;
                        end else begin
                            streak <= 4'd0;
                        end
                    end
                end
                ISSUE: begin
                    bus.m_ce <= 1'b0;
                    bus.m_we <= 1'b0;
                    latCnt   <= LAT_LOAD;
                    if (bus.m_we) bus.d_done <= 1'b1;
                    if (!ownData && bus.i_kill) killFlag <= 1'b1;
                end
                WAIT: begin
                    latCnt <= latCnt - 4'd1;
                    if (!ownData && bus.i_kill) killFlag <= 1'b1;
                    if (latCnt == 4'd1) begin
                        if (ownData) begin
                            bus.d_rdata <= bus.m_rdata;
                            bus.d_done  <= 1'b1;
                        end else if (!(killFlag || bus.i_kill)) begin
                            bus.i_rdata <= bus.m_rdata;
                            bus.i_done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a latency-accurate RAM model, a grant/done scoreboard monitor,
// and one task per scenario driving the fetch and data ports.
module tb_mem_port_arbiter;
    localparam int LAT  = 3;
    localparam int SMAX = 2;

    typedef struct packed {
        logic        isData;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] expGrant[$];
    exp_t        expDone[$];
    logic [31:0] eg;
    exp_t        ed;

    logic [31:0] mem [0:1023];
    logic [31:0] ramPipe [LAT];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data for a read sampled at edge E appears LAT-1 edges later.
    assign bus.m_rdata = ramPipe[LAT-1];
    always @(posedge clk) begin
        for (int s = LAT - 1; s > 0; s--) ramPipe[s] <= ramPipe[s-1];
        ramPipe[0] <= 32'hBAD0_BAD0;
        if (!resetn) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i;
            mem[4] <= 32'h2408_0005;
        end else if (bus.m_ce) begin
            if (bus.m_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.m_wmask[b]) mem[bus.m_addr[11:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
            end else begin
                ramPipe[0] <= mem[bus.m_addr[11:2]];
            end
        end
    end

    function automatic logic [31:0] ramWord(input logic [31:0] a);
        logic [31:0] idx;
        idx = {22'b0, a[11:2]};
        return (a == 32'h10) ? 32'h2408_0005 : 32'h1000_0000 + idx;
    endfunction

    function automatic exp_t mk(input logic d, input logic c, input logic [31:0] v);
        exp_t e;
        e.isData = d;
        e.chk    = c;
        e.data   = v;
        return e;
    endfunction

    // Scoreboard monitor: every RAM grant and every done pulse must match the queues.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.m_ce) begin
                checks++;
                if (expGrant.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected m_addr=%h expected no grant", bus.m_addr);
                end else begin
                    eg = expGrant.pop_front();
                    if (bus.m_addr !== eg) begin
                        errors++;
                        $display("FAIL grant_order m_addr=%h expected %h", bus.m_addr, eg);
                    end
                end
            end
            if (bus.i_done || bus.d_done) begin
                checks++;
                if (bus.i_done && bus.d_done) begin
                    errors++;
                    $display("FAIL done_exclusive i_done=1 d_done=1 expected at most one");
                end else if (expDone.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected i_done=%b d_done=%b expected none", bus.i_done, bus.d_done);
                end else begin
                    ed = expDone.pop_front();
                    if (ed.isData !== bus.d_done ||
                        (ed.chk && (bus.d_done ? bus.d_rdata : bus.i_rdata) !== ed.data)) begin
                        errors++;
                        $display("FAIL done_data d_done=%b i_rdata=%h d_rdata=%h expected isData=%b data=%h",
                                 bus.d_done, bus.i_rdata, bus.d_rdata, ed.isData, ed.data);
                    end
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.i_req = 0; bus.i_addr = 0; bus.i_kill = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_wmask = 0; bus.d_addr = 0; bus.d_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.m_ce, bus.m_we, bus.m_wmask, bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata,
             bus.i_done, bus.d_done, bus.busy, bus.stall_if, bus.stall_mem} !== '0) begin
            errors++;
            $display("FAIL reset_state m_ce=%b m_we=%b m_addr=%h i_rdata=%h d_rdata=%h busy=%b expected all 0",
                     bus.m_ce, bus.m_we, bus.m_addr, bus.i_rdata, bus.d_rdata, bus.busy);
        end
        nextCycle();
        resetn = 1'b1;
        nextCycle();
    endtask

    task automatic test_fetch_read();
        bus.i_addr = 32'h10;
        bus.i_req  = 1'b1;
        expGrant.push_back(32'h10);
        expDone.push_back(mk(1'b0, 1'b1, 32'h2408_0005));
        for (int k = 0; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (bus.m_ce !== 1'b1 || bus.m_addr !== 32'h10 || bus.m_we !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_issue m_ce=%b m_we=%b m_addr=%h expected 1 0 00000010", bus.m_ce, bus.m_we, bus.m_addr);
                end
            end
            checks++;
            if (k < LAT + 2) begin
                if (bus.stall_if !== 1'b1 || bus.i_done !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_wait cyc=%0d stall_if=%b i_done=%b expected 1 0", k, bus.stall_if, bus.i_done);
                end
            end else if (bus.i_done !== 1'b1 || bus.i_rdata !== 32'h2408_0005 || bus.stall_if !== 1'b0) begin
                errors++;
                $display("FAIL fetch_done i_done=%b i_rdata=%h stall_if=%b expected 1 24080005 0",
                         bus.i_done, bus.i_rdata, bus.stall_if);
            end
            nextCycle();
        end
        bus.i_req = 1'b0;
        nextCycle();
    endtask

    task automatic test_store();
        bus.d_we = 1'b1; bus.d_wmask = 4'b0011; bus.d_addr = 32'h0000_0102; bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_req = 1'b1;
        expGrant.push_back(32'h100);
        expDone.push_back(mk(1'b1, 1'b0, 32'h0));
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            checks++;
            if (k == 1) begin
                if (bus.m_ce !== 1'b1 || bus.m_we !== 1'b1 || bus.m_wmask !== 4'b0011 ||
                    bus.m_addr !== 32'h100 || bus.m_wdata !== 32'hDEAD_BEEF || bus.stall_mem !== 1'b1) begin
                    errors++;
                    $display("FAIL store_issue ce=%b we=%b mask=%b addr=%h wdata=%h expected 1 1 0011 00000100 deadbeef",
                             bus.m_ce, bus.m_we, bus.m_wmask, bus.m_addr, bus.m_wdata);
                end
            end else if (k == 2) begin
                if (bus.d_done !== 1'b1 || bus.stall_mem !== 1'b0 || bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL store_done d_done=%b stall_mem=%b busy=%b expected 1 0 0", bus.d_done, bus.stall_mem, bus.busy);
                end
            end else if (bus.stall_mem !== 1'b1 || bus.d_done !== 1'b0) begin
                errors++;
                $display("FAIL store_stall stall_mem=%b d_done=%b expected 1 0", bus.stall_mem, bus.d_done);
            end
            nextCycle();
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wmask = 4'b0;
        checks++;
        if (mem[64] !== 32'h1000_BEEF) begin
            errors++;
            $display("FAIL store_bytes mem=%h expected 1000beef", mem[64]);
        end
        nextCycle();
    endtask

    task automatic test_contention();
        int dDoneCyc, iIssueCyc, iDoneCyc;
        dDoneCyc = -1; iIssueCyc = -1; iDoneCyc = -1;
        bus.i_addr = 32'h20;  bus.i_req = 1'b1;
        bus.d_addr = 32'h200; bus.d_we = 1'b0; bus.d_req = 1'b1;
        expGrant.push_back(32'h200);
        expGrant.push_back(32'h20);
        expDone.push_back(mk(1'b1, 1'b1, ramWord(32'h200)));
        expDone.push_back(mk(1'b0, 1'b1, ramWord(32'h20)));
        for (int k = 0; k <= 2 * LAT + 6; k++) begin
            @(negedge clk);
            if (bus.d_done) dDoneCyc = k;
            if (bus.i_done) iDoneCyc = k;
            if (bus.m_ce && bus.m_addr == 32'h20) iIssueCyc = k;
            nextCycle();
            if (dDoneCyc >= 0) bus.d_req = 1'b0;
            if (iDoneCyc >= 0) bus.i_req = 1'b0;
        end
        checks++;
        if (dDoneCyc != LAT + 2 || iIssueCyc != LAT + 3 || iDoneCyc != 2 * LAT + 4) begin
            errors++;
            $display("FAIL contention_timing d_done=%0d i_issue=%0d i_done=%0d expected %0d %0d %0d",
                     dDoneCyc, iIssueCyc, iDoneCyc, LAT + 2, LAT + 3, 2 * LAT + 4);
        end
    endtask

    task automatic test_starvation();
        int  phase;
        bit  gotD, gotI;
        phase = 0;
        bus.i_addr = 32'h50; bus.i_kill = 1'b1; bus.i_req = 1'b1;
        bus.d_addr = 32'h300; bus.d_we = 1'b0; bus.d_req = 1'b1;
        expGrant.push_back(32'h300);
        expGrant.push_back(32'h304);
        expGrant.push_back(32'h50);
        expGrant.push_back(32'h308);
        expDone.push_back(mk(1'b1, 1'b1, ramWord(32'h300)));
        expDone.push_back(mk(1'b1, 1'b1, ramWord(32'h304)));
        expDone.push_back(mk(1'b0, 1'b1, ramWord(32'h50)));
        expDone.push_back(mk(1'b1, 1'b1, ramWord(32'h308)));
        for (int k = 0; k < 100 && phase < 4; k++) begin
            @(negedge clk);
            gotD = bus.d_done;
            gotI = bus.i_done;
            if (bus.m_ce && bus.m_addr == 32'h50) begin
                checks++;
                if (dut.streak !== 4'd0) begin
                    errors++;
                    $display("FAIL streak_clear streak=%0d expected 0", dut.streak);
                end
            end
            nextCycle();
            case (phase)
                0: if (gotD) begin bus.d_addr = 32'h304; phase = 1; end
                1: if (gotD) begin
                    checks++;
                    if (dut.streak !== 4'(SMAX)) begin
                        errors++;
                        $display("FAIL streak_sat streak=%0d expected %0d", dut.streak, SMAX);
                    end
                    bus.d_addr = 32'h308; bus.i_kill = 1'b0; phase = 2;
                end
                2: if (gotI) begin bus.i_req = 1'b0; phase = 3; end
                3: if (gotD) begin bus.d_req = 1'b0; phase = 4; end
                default: ;
            endcase
        end
        checks++;
        if (phase != 4) begin
            errors++;
            $display("FAIL starvation_timeout phase=%0d expected 4", phase);
        end
        bus.d_req = 1'b0; bus.i_req = 1'b0; bus.i_kill = 1'b0;
        nextCycle();
    endtask

    task automatic test_kill();
        bus.i_addr = 32'h60; bus.i_req = 1'b1;
        expGrant.push_back(32'h60);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 5) begin
                checks++;
                if (bus.busy !== (k <= LAT + 1)) begin
                    errors++;
                    $display("FAIL kill_busy cyc=%0d busy=%b expected %b", k, bus.busy, k <= LAT + 1);
                end
            end
            nextCycle();
            if (k == 2) begin bus.i_kill = 1'b1; bus.i_req = 1'b0; end
            if (k == 3) bus.i_kill = 1'b0;
        end
        checks++;
        if (bus.i_rdata !== ramWord(32'h50)) begin
            errors++;
            $display("FAIL kill_hold i_rdata=%h expected %h", bus.i_rdata, ramWord(32'h50));
        end
        bus.i_addr = 32'h70; bus.i_req = 1'b1;
        expGrant.push_back(32'h70);
        expDone.push_back(mk(1'b0, 1'b1, ramWord(32'h70)));
        for (int k = 0; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (k == LAT + 2) begin
                checks++;
                if (bus.i_done !== 1'b1 || bus.i_rdata !== ramWord(32'h70)) begin
                    errors++;
                    $display("FAIL kill_next i_done=%b i_rdata=%h expected 1 %h", bus.i_done, bus.i_rdata, ramWord(32'h70));
                end
            end
            nextCycle();
        end
        bus.i_req = 1'b0;
        nextCycle();
    endtask

    task automatic test_reset_midwait();
        bus.d_addr = 32'h400; bus.d_we = 1'b0; bus.d_req = 1'b1;
        expGrant.push_back(32'h400);
        expGrant.push_back(32'h400);
        expDone.push_back(mk(1'b1, 1'b1, ramWord(32'h400)));
        for (int k = 0; k <= LAT + 6; k++) begin
            @(negedge clk);
            if (k == 4) begin
                checks++;
                if ({bus.m_ce, bus.m_we, bus.m_wmask, bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata,
                     bus.i_done, bus.d_done, bus.busy} !== '0) begin
                    errors++;
                    $display("FAIL rst_clear m_ce=%b m_addr=%h i_rdata=%h d_rdata=%h busy=%b expected all 0",
                             bus.m_ce, bus.m_addr, bus.i_rdata, bus.d_rdata, bus.busy);
                end
            end
            if (k == 5) begin
                checks++;
                if (bus.m_ce !== 1'b1 || bus.m_addr !== 32'h400) begin
                    errors++;
                    $display("FAIL rst_restart m_ce=%b m_addr=%h expected 1 00000400", bus.m_ce, bus.m_addr);
                end
            end
            checks++;
            if (bus.d_done !== (k == LAT + 6)) begin
                errors++;
                $display("FAIL rst_done cyc=%0d d_done=%b expected %b", k, bus.d_done, k == LAT + 6);
            end
            nextCycle();
            if (k == 2) resetn = 1'b0;
            if (k == 3) resetn = 1'b1;
        end
        bus.d_req = 1'b0;
        nextCycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_read();
        test_store();
        test_contention();
        test_starvation();
        test_kill();
        test_reset_midwait();
        repeat (4) nextCycle();
        checks++;
        if (expGrant.size() != 0 || expDone.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain grants_left=%0d dones_left=%0d expected 0 0", expGrant.size(), expDone.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
